rtc_lectura_secuencial: RTL and testbench

RTC_LECTURA_SECUENCIAL -- requirements
Module: rtc_lectura_secuencial

---
 rtl/rtc_lectura_secuencial.sv | 216 +++++++++++++++++++++
 tb/tb_rtc_lectura_secuencial.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_lectura_secuencial.sv
// rtc_lectura_secuencial: reads the six RTC time/date registers
// (0x21..0x26) in one burst, one register per transaction. The values are
// kept in shadow registers and copied to the outputs together, only when
// every nibble is valid BCD.
//
// Transaction handshake with the protocol block:
// - IndicadorMaquina=1 together with a stable address is the request.
// - Both are held unchanged until contador_todo reaches 0x4A, which ends
//   the transaction.
// - data_vga is captured when contador_todo==0x40.
// - IndicadorMaquina drops for at least one cycle between transactions.
// - If a transaction exceeds TIMEOUT_CICLOS, the burst is abandoned.
module rtc_lectura_secuencial #(
  parameter int unsigned REFRESH_CICLOS = 100000000,
  parameter int unsigned TIMEOUT_CICLOS = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_lectura,
  input  logic [6:0] contador_todo,
  input  logic [7:0] data_vga,
  output logic [7:0] address,
  output logic       IndicadorMaquina,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       busy,
  output logic       dato_valido,
  output logic       error_lectura,
  output logic [2:0] estado_dbg
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    EMITIR      = 3'd1,
    ESPERA_DATO = 3'd2,
    ESPERA_FIN  = 3'd3,
    SIGUIENTE   = 3'd4,
    COMMIT      = 3'd5
  } estado_t;

  localparam logic [31:0] REFRESH_LIM = 32'(REFRESH_CICLOS - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CICLOS - 1);
  localparam logic [6:0]  CNT_DATO    = 7'h40;
  localparam logic [6:0]  CNT_FIN     = 7'h4A;
  localparam logic [7:0]  ADDR_BASE   = 8'h21;

  estado_t         state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [5:0][7:0] time_q, time_d;
  logic [7:0]      address_q, address_d;
  logic            ind_q, ind_d;
  logic            busy_q, busy_d;
  logic            valido_q, valido_d;
  logic            error_q, error_d;
  logic [31:0]     refresh_q, refresh_d;
  logic [31:0]     timeout_q, timeout_d;
  logic            refresh_exp;
  logic [5:0][7:0] shadow_masked;

  function automatic logic bcd_ok(input logic [5:0][7:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (v[i][7:4] > 4'd9 || v[i][3:0] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Bit 7 of the seconds register is a control bit on the RTC, so it is
  // ignored for validation and never reaches the outputs.
  always_comb begin
    shadow_masked       = shadow_q;
    shadow_masked[0][7] = 1'b0;
  end

  // Next-state logic: sequencing, refresh/timeout counters, shadow capture and commit.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    time_d      = time_q;
    valido_d    = 1'b0;
    error_d     = error_q;
    refresh_d   = refresh_q;
    timeout_d   = timeout_q;
    refresh_exp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REFRESH_CICLOS != 0) begin
          if (refresh_q == REFRESH_LIM) begin
            refresh_exp = 1'b1;
            refresh_d   = 32'd0;
          end else begin
            refresh_d = refresh_q + 32'd1;
          end
        end
        // A simultaneous start pulse and refresh expiry start only one burst.
        if (start_lectura || refresh_exp) begin
          state_d   = EMITIR;
          idx_d     = 3'd0;
          error_d   = 1'b0;
          refresh_d = 32'd0;
        end
      end
      EMITIR: begin
        timeout_d = 32'd0;
        state_d   = ESPERA_DATO;
      end
      ESPERA_DATO: begin
        if (timeout_q == TIMEOUT_LIM) begin
          error_d   = 1'b1;
          timeout_d = 32'd0;
          idx_d     = 3'd0;
          state_d   = IDLE;
        end else begin
          timeout_d = timeout_q + 32'd1;
          if (contador_todo == CNT_DATO) begin
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) shadow_d[i] = data_vga;
            end
            state_d = ESPERA_FIN;
          end
        end
      end
      ESPERA_FIN: begin
        if (timeout_q == TIMEOUT_LIM) begin
          error_d   = 1'b1;
          timeout_d = 32'd0;
          idx_d     = 3'd0;
          state_d   = IDLE;
        end else begin
          timeout_d = timeout_q + 32'd1;
          if (contador_todo == CNT_FIN) state_d = SIGUIENTE;
        end
      end
      SIGUIENTE: begin
        if (idx_q == 3'd5) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = EMITIR;
        end
      end
      COMMIT: begin
        // All six values change together or not at all.
        if (bcd_ok(shadow_masked)) begin
          time_d   = shadow_masked;
          valido_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        idx_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Bus-facing outputs are registered from the next state, so they stay constant during a transaction.
  always_comb begin
    busy_d    = (state_d != IDLE);
    ind_d     = (state_d == EMITIR) || (state_d == ESPERA_DATO) || (state_d == ESPERA_FIN);
    address_d = ind_d ? (ADDR_BASE + {5'd0, idx_d}) : 8'h00;
  end

  // State and datapath registers; reset aborts any burst and drops the shadows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      shadow_q  <= '0;
      time_q    <= '0;
      address_q <= 8'h00;
      ind_q     <= 1'b0;
      busy_q    <= 1'b0;
      valido_q  <= 1'b0;
      error_q   <= 1'b0;
      refresh_q <= 32'd0;
      timeout_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      time_q    <= time_d;
      address_q <= address_d;
      ind_q     <= ind_d;
      busy_q    <= busy_d;
      valido_q  <= valido_d;
      error_q   <= error_d;
      refresh_q <= refresh_d;
      timeout_q <= timeout_d;
    end
  end

  assign address          = address_q;
  assign IndicadorMaquina = ind_q;
  assign segundos         = time_q[0];
  assign minutos          = time_q[1];
  assign horas            = time_q[2];
  assign dia              = time_q[3];
  assign mes              = time_q[4];
  assign anio             = time_q[5];
  assign busy             = busy_q;
  assign dato_valido      = valido_q;
  assign error_lectura    = error_q;
  assign estado_dbg       = state_q;

endmodule

// File: tb/tb_rtc_lectura_secuencial.sv
// Bench for rtc_lectura_secuencial. The bench contains:
// - a protocol responder that emulates the RTC transaction counter;
// - a scoreboard that records expected transactions, commits and
//   end-of-burst state;
// - a second instance that checks the automatic refresh period.
module tb_rtc_lectura_secuencial;

  localparam int TMO   = 4096;
  localparam int TMO_R = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_lectura;
  logic [6:0] contador_todo;
  logic [7:0] data_vga;
  logic [7:0] address;
  logic       IndicadorMaquina;
  logic [7:0] segundos, minutos, horas, dia, mes, anio;
  logic       busy, dato_valido, error_lectura;
  logic [2:0] estado_dbg;

  rtc_lectura_secuencial #(.REFRESH_CICLOS(0), .TIMEOUT_CICLOS(TMO)) dut (
    .clk(clk), .reset(reset), .start_lectura(start_lectura),
    .contador_todo(contador_todo), .data_vga(data_vga),
    .address(address), .IndicadorMaquina(IndicadorMaquina),
    .segundos(segundos), .minutos(minutos), .horas(horas),
    .dia(dia), .mes(mes), .anio(anio),
    .busy(busy), .dato_valido(dato_valido), .error_lectura(error_lectura),
    .estado_dbg(estado_dbg)
  );

  // Refresh-only instance: no start pulses; the bus is stuck, so every burst times out.
  logic       rst_r;
  logic [7:0] address_r, seg_r, min_r, hor_r, dia_r, mes_r, anio_r;
  logic       ind_r, busy_r, valido_r, error_r;
  logic [2:0] estado_r;

  rtc_lectura_secuencial #(.REFRESH_CICLOS(1000), .TIMEOUT_CICLOS(TMO_R)) dut_r (
    .clk(clk), .reset(rst_r), .start_lectura(1'b0),
    .contador_todo(7'h00), .data_vga(8'h00),
    .address(address_r), .IndicadorMaquina(ind_r),
    .segundos(seg_r), .minutos(min_r), .horas(hor_r),
    .dia(dia_r), .mes(mes_r), .anio(anio_r),
    .busy(busy_r), .dato_valido(valido_r), .error_lectura(error_r),
    .estado_dbg(estado_r)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model state ----------------
  logic [7:0]  resp [6];
  logic [47:0] model_time = '0;
  bit          stall = 1'b0;
  bit          refresh_done = 1'b0;

  logic [7:0]  exp_addr_q [$];
  logic [47:0] exp_commit_q [$];
  logic [48:0] exp_end_q [$];

  function automatic bit model_ok(input logic [47:0] t);
    int b;
    for (int f = 0; f < 6; f++) begin
      b = int'(t[f*8 +: 8]);
      if ((b / 16) > 9 || (b % 16) > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [47:0] out_time();
    return {anio, mes, dia, horas, minutos, segundos};
  endfunction

  // ---------------- protocol responder ----------------
  initial begin
    int ai;
    contador_todo = 7'h00;
    data_vga      = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset)                contador_todo = 7'h00;
      else if (stall)            contador_todo = 7'h10;
      else if (IndicadorMaquina) begin
        if (contador_todo != 7'h4A) contador_todo = contador_todo + 7'd1;
      end else                   contador_todo = 7'h00;
      ai = int'(address) - 'h21;
      if (ai >= 0 && ai < 6 && contador_todo >= 7'h3D && contador_todo <= 7'h44)
        data_vga = resp[ai];
      else
        data_vga = 8'hEE;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit          prev_ind = 1'b0, prev_busy = 1'b0, stab_bad = 1'b0;
    logic [7:0]  held_addr = 8'h00;
    logic [7:0]  ea;
    logic [47:0] ec;
    logic [48:0] ee;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_ind = 1'b0; prev_busy = 1'b0; stab_bad = 1'b0;
      end else begin
        if (IndicadorMaquina && !prev_ind) begin
          n_vec++;
          if (exp_addr_q.size() == 0) begin
            n_err++; $display("FAIL txn_addr: unexpected transaction, got %02h, none expected", address);
          end else begin
            ea = exp_addr_q.pop_front();
            if (address !== ea) begin
              n_err++; $display("FAIL txn_addr: got %02h expected %02h", address, ea);
            end
          end
          held_addr = address; stab_bad = 1'b0;
        end
        if (IndicadorMaquina && prev_ind && address !== held_addr) stab_bad = 1'b1;
        if (!IndicadorMaquina && prev_ind) begin
          n_vec++;
          if (stab_bad) begin
            n_err++; $display("FAIL txn_stable: address changed during transaction, start %02h now %02h", held_addr, address);
          end
        end
        if (dato_valido) begin
          n_vec++;
          if (exp_commit_q.size() == 0) begin
            n_err++; $display("FAIL commit: unexpected dato_valido, outputs %012h", out_time());
          end else begin
            ec = exp_commit_q.pop_front();
            if (out_time() !== ec) begin
              n_err++; $display("FAIL commit: got %012h expected %012h", out_time(), ec);
            end
          end
        end
        if (!busy && prev_busy) begin
          n_vec++;
          if (exp_end_q.size() == 0) begin
            n_err++; $display("FAIL burst_end: unexpected end of burst");
          end else begin
            ee = exp_end_q.pop_front();
            if ({error_lectura, out_time()} !== ee || address !== 8'h00 || IndicadorMaquina !== 1'b0) begin
              n_err++;
              $display("FAIL burst_end: err/time got %0b/%012h expected %0b/%012h, addr %02h ind %0b",
                       error_lectura, out_time(), ee[48], ee[47:0], address, IndicadorMaquina);
            end
          end
        end
        prev_ind  = IndicadorMaquina;
        prev_busy = busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic gen_resp(input bit make_bad);
    int f;
    resp[0] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    for (int i = 1; i < 6; i++) resp[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    if (make_bad) begin
      f = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) resp[f][3:0] = 4'($urandom_range(10, 15));
      else                           resp[f][7:4] = 4'($urandom_range(10, 15));
    end
  endtask

  task automatic set_resp(input logic [47:0] v);
    for (int i = 0; i < 6; i++) resp[i] = v[i*8 +: 8];
  endtask

  task automatic push_expect(input bit stall_mode);
    logic [47:0] cand;
    bit ok;
    if (stall_mode) begin
      exp_addr_q.push_back(8'h21);
      exp_end_q.push_back({1'b1, model_time});
    end else begin
      for (int i = 0; i < 6; i++) exp_addr_q.push_back(8'(8'h21 + i));
      cand = {resp[5], resp[4], resp[3], resp[2], resp[1], resp[0] & 8'h7F};
      ok = model_ok(cand);
      if (ok) begin
        model_time = cand;
        exp_commit_q.push_back(cand);
      end
      exp_end_q.push_back({!ok, model_time});
    end
  endtask

  task automatic run_burst(input bit stall_mode, input bit mid_start, output int busy_cycles);
    bit done = 1'b0, pulsed = 1'b0;
    push_expect(stall_mode);
    stall = stall_mode;
    @(negedge clk); start_lectura = 1'b1;
    @(negedge clk); start_lectura = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 6000 && !done; c++) begin
      if (busy) busy_cycles++; else done = 1'b1;
      if (!done && mid_start && !pulsed && IndicadorMaquina && address == 8'h23) begin
        start_lectura = 1'b1; pulsed = 1'b1;
      end else begin
        start_lectura = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    start_lectura = 1'b0;
    n_vec++;
    if (busy_cycles == 0 || !done) begin
      n_err++; $display("FAIL burst_run: busy cycles %0d, finished %0b (required: started and finished)", busy_cycles, done);
    end
    stall = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if ({out_time(), address, IndicadorMaquina, busy, dato_valido, error_lectura, estado_dbg} !== '0) begin
      n_err++;
      $display("FAIL %s: time %012h addr %02h ind %0b busy %0b valid %0b err %0b state %0d (required all zero)",
               tag, out_time(), address, IndicadorMaquina, busy, dato_valido, error_lectura, estado_dbg);
    end
  endtask

  // ---------------- refresh period checker (second instance) ----------------
  initial begin
    int gap;
    bit seen;
    rst_r = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_r = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 1100 && !seen; c++) begin @(negedge clk); seen = busy_r; end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL refresh_first: no burst within 1100 cycles, got busy %0b required 1", busy_r); end
    for (int g = 0; g < 3 && seen; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin @(negedge clk); seen = !busy_r; end
      n_vec++;
      if (!seen || error_r !== 1'b1) begin
        n_err++; $display("FAIL refresh_timeout: ended %0b err %0b (required 1/1)", seen, error_r);
      end
      gap = 0;
      while (!busy_r && gap < 1100) begin gap++; @(negedge clk); end
      n_vec++;
      if (gap != 1000) begin n_err++; $display("FAIL refresh_gap: got %0d idle cycles required 1000", gap); end
      seen = 1'b1;
    end
    refresh_done = 1'b1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int bc, idle_busy;
    bit hit;
    reset = 1'b0;
    start_lectura = 1'b0;
    for (int i = 0; i < 6; i++) resp[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("after_release");

    // Known-good burst
    set_resp({8'h24, 8'h02, 8'h28, 8'h12, 8'h30, 8'h45});
    run_burst(1'b0, 1'b0, bc);

    // Invalid month, then a good burst clears the flag
    set_resp({8'h24, 8'h1A, 8'h28, 8'h12, 8'h30, 8'h45});
    run_burst(1'b0, 1'b0, bc);
    gen_resp(1'b0);
    run_burst(1'b0, 1'b0, bc);

    // Start pulse during transaction 3 must be ignored
    gen_resp(1'b0);
    run_burst(1'b0, 1'b1, bc);

    // Randomized bursts
    for (int k = 0; k < 14; k++) begin
      gen_resp($urandom_range(0, 3) == 0);
      run_burst(1'b0, $urandom_range(0, 3) == 0, bc);
    end

    // Stalled bus: timeout
    run_burst(1'b1, 1'b0, bc);
    n_vec++;
    if (bc < TMO || bc > TMO + 3 || error_lectura !== 1'b1 || IndicadorMaquina !== 1'b0) begin
      n_err++; $display("FAIL timeout: busy %0d cycles err %0b ind %0b (required %0d..%0d, 1, 0)",
                        bc, error_lectura, IndicadorMaquina, TMO, TMO + 3);
    end

    // Auto refresh disabled: nothing may start
    idle_busy = 0;
    for (int c = 0; c < 3000; c++) begin @(negedge clk); if (busy) idle_busy++; end
    n_vec++;
    if (idle_busy != 0) begin n_err++; $display("FAIL no_refresh: busy %0d cycles required 0", idle_busy); end

    // Reset during transaction 4
    set_resp({8'h24, 8'h02, 8'h28, 8'h12, 8'h30, 8'h45});
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(8'(8'h21 + i));
    @(negedge clk); start_lectura = 1'b1;
    @(negedge clk); start_lectura = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      hit = IndicadorMaquina && address == 8'h24;
    end
    n_vec++;
    if (!hit || exp_addr_q.size() != 0) begin
      n_err++; $display("FAIL reset_reach: reached txn4 %0b pending %0d (required 1, 0)", hit, exp_addr_q.size());
    end
    #2 reset = 1'b0;
    #1 check_zero("reset_mid_burst");
    exp_addr_q.delete(); exp_commit_q.delete(); exp_end_q.delete();
    model_time = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    idle_busy = 0;
    for (int c = 0; c < 600; c++) begin @(negedge clk); if (busy || dato_valido) idle_busy++; end
    n_vec++;
    if (idle_busy != 0 || out_time() !== 48'h0) begin
      n_err++; $display("FAIL post_reset: active %0d time %012h (required 0, 0)", idle_busy, out_time());
    end

    // Recovery burst after reset
    set_resp({8'h24, 8'h02, 8'h28, 8'h12, 8'h30, 8'h45});
    run_burst(1'b0, 1'b0, bc);

    for (int c = 0; c < 20000 && !refresh_done; c++) @(negedge clk);
    n_vec++;
    if (!refresh_done) begin n_err++; $display("FAIL refresh_wait: checker done %0b required 1", refresh_done); end
    n_vec++;
    if (exp_addr_q.size() + exp_commit_q.size() + exp_end_q.size() != 0) begin
      n_err++; $display("FAIL leftover: %0d/%0d/%0d expected events never seen (required 0)",
                        exp_addr_q.size(), exp_commit_q.size(), exp_end_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
